// File: rtl/fetch_line_buffer_if.sv
// rtl/fetch_line_buffer_if.sv - fetch stage memory, redirect and instruction handshake bundle
interface fetch_line_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_line;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ready;

  modport master (
    output mem_address, inst, inst_pc, inst_valid,
    input  mem_line, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_address, inst, inst_pc, inst_valid,
    output mem_line, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_line_buffer.sv
// rtl/fetch_line_buffer.sv - PC owner that fetches 128-bit lines and streams 32-bit instructions
module fetch_line_buffer #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int MEM_LATENCY = 5
) (
  input  logic                CLk,
  input  logic                rst_n,
  fetch_line_buffer_if.master bus
);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic {S_WAIT, S_DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] line;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] pc_next;
  logic [1:0]        slot;

  assign slot    = pc[3:2];
  assign pc_next = pc + ADDR_W'(4);

  assign bus.mem_address = mem_addr;
  assign bus.inst_valid  = (state == S_DRAIN);
  assign bus.inst_pc     = pc;
  assign bus.inst        = line[32*slot +: 32];

  // Redirect outranks both line capture and handshake advance on the same edge.
  always_ff @(posedge CLk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_WAIT;
      pc       <= '0;
      mem_addr <= '0;
      line     <= '0;
      wait_cnt <= '0;
    end else if (bus.redirect_valid) begin
      pc       <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      mem_addr <= {bus.redirect_pc[ADDR_W-1:4], 4'b0000};
      wait_cnt <= '0;
      state    <= S_WAIT;
    end else begin
      case (state)
        S_WAIT: begin
          if (wait_cnt == LAST_CNT) begin
            line     <= bus.mem_line;
            wait_cnt <= '0;
            state    <= S_DRAIN;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (bus.inst_ready) begin
            pc <= pc_next;
            if (slot == 2'd3) begin
              mem_addr <= {pc_next[ADDR_W-1:4], 4'b0000};
              wait_cnt <= '0;
              state    <= S_WAIT;
            end
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_line_buffer.sv
// tb/tb_fetch_line_buffer.sv - scoreboard bench for fetch_line_buffer
module tb_fetch_line_buffer;
  logic CLk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];

  fetch_line_buffer_if #(.ADDR_W(32), .LINE_W(128)) bus ();

  fetch_line_buffer #(.ADDR_W(32), .LINE_W(128), .MEM_LATENCY(5)) dut (
    .CLk   (CLk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 CLk = ~CLk;

  // Memory image: byte at address i holds i[7:0].
  always_comb begin
    bus.mem_line = '0;
    for (int k = 0; k < 16; k++)
      bus.mem_line[8*k +: 8] = bus.mem_address[7:0] + 8'(k);
  end

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  always @(negedge CLk) begin
    if (rst_n && bus.inst_valid && bus.inst_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got inst=%h pc=%h, required no delivery", bus.inst, bus.inst_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.inst !== e.inst || bus.inst_pc !== e.pc) begin
          fails++;
          $display("FAIL sb_data: got inst=%h pc=%h, required inst=%h pc=%h",
                   bus.inst, bus.inst_pc, e.inst, e.pc);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLk);
    #1;
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.pc   = a;
    e.inst = exp_inst(a);
    sb.push_back(e);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.inst_valid && n < 40) begin
      step();
      n++;
    end
    if (!bus.inst_valid) n = -1;
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    bus.inst_ready = 1'b1;
    step();
    step();
    tests++;
    if (bus.inst_valid !== 1'b0 || bus.mem_address !== 32'h0 || bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: got valid=%b addr=%h inst=%h pc=%h, required 0/0/0/0",
               bus.inst_valid, bus.mem_address, bus.inst, bus.inst_pc);
    end
    for (int a = 0; a < 32; a += 4) push(32'(a));
    rst_n = 1'b1;
    wait_valid(n);
    tests++;
    if (n !== 5) begin
      fails++;
      $display("FAIL first_latency: got %0d cycles, required 5", n);
    end
    repeat (4) step();
    tests++;
    if (bus.mem_address !== 32'h10 || bus.inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL line_exit: got addr=%h valid=%b, required 00000010/0", bus.mem_address, bus.inst_valid);
    end
    wait_valid(n);
    tests++;
    if (n !== 5) begin
      fails++;
      $display("FAIL refill_gap: got %0d cycles, required 5", n);
    end
    repeat (4) step();
    bus.inst_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    redirect(32'h50);
    wait_valid(n);
    for (int a = 'h50; a < 'h60; a += 4) push(32'(a));
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h57565554 || bus.inst_pc !== 32'h54 || bus.mem_address !== 32'h50) begin
        fail_hold(i);
      end
    end
    bus.inst_ready = 1'b1;
    repeat (3) step();
    bus.inst_ready = 1'b0;
    tests++;
    if (sb.size() != 0 || bus.mem_address !== 32'h60) begin
      fails++;
      $display("FAIL bp_resume: got pending=%0d addr=%h, required 0/00000060", sb.size(), bus.mem_address);
    end
  endtask

  task automatic fail_hold(input int i);
    fails++;
    $display("FAIL bp_hold[%0d]: got valid=%b inst=%h pc=%h addr=%h, required 1/57565554/00000054/00000050",
             i, bus.inst_valid, bus.inst, bus.inst_pc, bus.mem_address);
  endtask

  task automatic test_redirect_drain();
    int n;
    wait_valid(n);
    redirect(32'h26);
    tests++;
    if (bus.inst_valid !== 1'b0 || bus.mem_address !== 32'h20) begin
      fails++;
      $display("FAIL rd_drain_addr: got valid=%b addr=%h, required 0/00000020", bus.inst_valid, bus.mem_address);
    end
    push(32'h24); push(32'h28); push(32'h2C);
    wait_valid(n);
    tests++;
    if (n !== 5 || bus.inst_pc !== 32'h24) begin
      fails++;
      $display("FAIL rd_drain_entry: got %0d cycles pc=%h, required 5/00000024", n, bus.inst_pc);
    end
    bus.inst_ready = 1'b1;
    repeat (3) step();
    bus.inst_ready = 1'b0;
    tests++;
    if (bus.mem_address !== 32'h30 || bus.inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL rd_drain_next: got addr=%h valid=%b, required 00000030/0", bus.mem_address, bus.inst_valid);
    end
  endtask

  task automatic test_redirect_wait();
    int n;
    repeat (3) step();
    redirect(32'h40);
    tests++;
    if (bus.mem_address !== 32'h40 || bus.inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL rd_wait_addr: got addr=%h valid=%b, required 00000040/0", bus.mem_address, bus.inst_valid);
    end
    wait_valid(n);
    tests++;
    if (n !== 5 || bus.inst !== 32'h43424140 || bus.inst_pc !== 32'h40) begin
      fails++;
      $display("FAIL rd_wait_restart: got %0d cycles inst=%h pc=%h, required 5/43424140/00000040",
               n, bus.inst, bus.inst_pc);
    end
    push(32'h40);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    push(32'h44); push(32'h48); push(32'h4C);
    bus.inst_ready = 1'b1;
    step();
    step();
    redirect(32'h1F8);
    bus.inst_ready = 1'b0;
    tests++;
    if (bus.mem_address !== 32'h1F0 || bus.inst_pc !== 32'h1F8 || bus.inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL rd_hs_target: got addr=%h pc=%h valid=%b, required 000001f0/000001f8/0",
               bus.mem_address, bus.inst_pc, bus.inst_valid);
    end
    push(32'h1F8); push(32'h1FC);
    wait_valid(n);
    tests++;
    if (n !== 5) begin
      fails++;
      $display("FAIL rd_hs_latency: got %0d cycles, required 5", n);
    end
    bus.inst_ready = 1'b1;
    step();
    step();
    bus.inst_ready = 1'b0;
    tests++;
    if (bus.mem_address !== 32'h200) begin
      fails++;
      $display("FAIL rd_hs_next: got addr=%h, required 00000200", bus.mem_address);
    end
  endtask

  task automatic test_wrap();
    int n;
    redirect(32'hFFFF_FFF9);
    tests++;
    if (bus.mem_address !== 32'hFFFF_FFF0 || bus.inst_pc !== 32'hFFFF_FFF8) begin
      fails++;
      $display("FAIL wrap_entry: got addr=%h pc=%h, required fffffff0/fffffff8", bus.mem_address, bus.inst_pc);
    end
    push(32'hFFFF_FFF8); push(32'hFFFF_FFFC);
    wait_valid(n);
    bus.inst_ready = 1'b1;
    step();
    step();
    bus.inst_ready = 1'b0;
    tests++;
    if (bus.mem_address !== 32'h0 || bus.inst_pc !== 32'h0 || bus.inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL wrap_next: got addr=%h pc=%h valid=%b, required 0/0/0",
               bus.mem_address, bus.inst_pc, bus.inst_valid);
    end
  endtask

  task automatic test_async_reset();
    int n;
    wait_valid(n);
    push(32'h0);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.inst_valid !== 1'b0 || bus.mem_address !== 32'h0 || bus.inst_pc !== 32'h0 || bus.inst !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: got valid=%b addr=%h pc=%h inst=%h, required 0/0/0/0",
               bus.inst_valid, bus.mem_address, bus.inst_pc, bus.inst);
    end
    step();
    rst_n = 1'b1;
    wait_valid(n);
    tests++;
    if (n !== 5 || bus.inst_pc !== 32'h0 || bus.inst !== 32'h03020100) begin
      fails++;
      $display("FAIL refetch: got %0d cycles pc=%h inst=%h, required 5/00000000/03020100", n, bus.inst_pc, bus.inst);
    end
    push(32'h0);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    step();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drained: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    test_reset();
    test_backpressure();
    test_redirect_drain();
    test_redirect_wait();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
